// File: rtl/sigma_np.sv
// rtl/sigma_np.sv - N-point frame accumulator with sum and floor-mean outputs
module sigma_np #(
    parameter int DW    = 8,
    parameter int LOG2N = 4,
    parameter int SM_IN = 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [DW-1:0]         data_in,
    input  logic                  syn_in,
    input  logic                  clr,
    output logic [DW+LOG2N-1:0]   data_out,
    output logic [DW-1:0]         avg_out,
    output logic                  syn_out,
    output logic [LOG2N-1:0]      cnt_out
);

    localparam int W = DW + LOG2N;

    logic             syn_d;
    logic             pulse;
    logic [DW-1:0]    d;
    logic [W-1:0]     d_ext;
    logic [W-1:0]     sigma;
    logic [W-1:0]     sum_next;
    logic [LOG2N-1:0] cnt;

    always_comb begin
        pulse = syn_in & ~syn_d;
        d     = data_in;
        // Negating a zero magnitude yields zero, so negative zero needs no special case.
        if (SM_IN != 0) begin
            if (data_in[DW-1])
                d = DW'(0) - {1'b0, data_in[DW-2:0]};
            else
                d = {1'b0, data_in[DW-2:0]};
        end
        d_ext    = {{LOG2N{d[DW-1]}}, d};
        sum_next = sigma + d_ext;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            syn_d    <= 1'b1;
            sigma    <= '0;
            cnt      <= '0;
            data_out <= '0;
            avg_out  <= '0;
            syn_out  <= 1'b0;
        end else begin
            syn_d   <= syn_in;
            syn_out <= 1'b0;
            if (clr) begin
                sigma <= '0;
                cnt   <= '0;
            end else if (pulse) begin
                if (&cnt) begin
                    data_out <= sum_next;
                    // Upper DW bits of the full-width sum are the floor-shifted mean.
                    avg_out  <= sum_next[LOG2N +: DW];
                    sigma    <= '0;
                    cnt      <= '0;
                    syn_out  <= 1'b1;
                end else begin
                    sigma <= sum_next;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

    assign cnt_out = cnt;

endmodule

// File: doc/sigma_np.md
SIGMA_NP -- requirements
Module: sigma_np

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning input sample width in bits (DW >= 2).
REQ-002 The block SHALL have parameter LOG2N, default 4, meaning log2 of points per frame; N = 2^LOG2N (LOG2N >= 1).
REQ-003 The block SHALL have parameter SM_IN, default 1, meaning 1 = data_in is sign-magnitude and 0 = data_in is two's complement.
REQ-004 The block SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port res, input, width 1, the reset: one clock, synchronous, active-high.
REQ-006 The block SHALL have port data_in, input, width DW, the sample, taken in the cycle a sync pulse is detected.
REQ-007 The block SHALL have port syn_in, input, width 1, the sample strobe; each rising edge marks one sample.
REQ-008 The block SHALL have port clr, input, width 1, a synchronous frame restart.
REQ-009 The block SHALL have port data_out, output, width DW+LOG2N, the two's complement N-point sum of the last completed frame.
REQ-010 The block SHALL have port avg_out, output, width DW, the two's complement mean of the last completed frame.
REQ-011 The block SHALL have port syn_out, output, width 1, a one-cycle strobe marking new data_out/avg_out.
REQ-012 The block SHALL have port cnt_out, output, width LOG2N, the samples accumulated so far in the current frame.

Function
REQ-013 The block SHALL register syn_in into syn_d each cycle; pulse = syn_in & ~syn_d (rising-edge detect, combinational).
REQ-014 For SM_IN=1, the block SHALL convert data_in to two's complement d: positive magnitude unchanged, negative magnitude negated; 1 followed by zeros (negative zero) SHALL map to 0.
REQ-015 For SM_IN=0, the block SHALL take d = data_in unchanged.
REQ-016 The block SHALL sign-extend d to DW+LOG2N bits before accumulation; the accumulator SHALL be DW+LOG2N bits wide, so no overflow is possible and none SHALL be flagged.
REQ-017 On a pulse with cnt < N-1, the block SHALL set sigma <= sigma + d_ext and cnt <= cnt+1.
REQ-018 On a pulse with cnt == N-1, the block SHALL set data_out <= sigma + d_ext (the frame includes all N samples).
REQ-019 On that same pulse, the block SHALL also set avg_out <= (sigma + d_ext) arithmetically shifted right by LOG2N (floor, toward minus infinity), sigma <= 0, cnt <= 0 and syn_out <= 1.
REQ-020 syn_out SHALL be 1 for exactly one cycle, the cycle after the edge that sampled the N-th pulse, and 0 in all other cycles.
REQ-021 data_out and avg_out SHALL hold their values until the next frame completes.
REQ-022 If clr=1, the block SHALL set sigma <= 0 and cnt <= 0 and SHALL leave data_out and avg_out unchanged.
REQ-023 If clr=1 and a pulse occur in the same cycle, clr SHALL win: the sample is discarded and syn_out stays 0.
REQ-024 Cycles without a pulse SHALL leave sigma and cnt unchanged.
REQ-025 cnt_out SHALL equal cnt.
REQ-026 A syn_in held high SHALL yield only one pulse; the minimum pulse spacing is 2 cycles (syn_in high 1 cycle, low 1 cycle).

Reset
REQ-027 While res=1 at a clock edge, the block SHALL set sigma=0, cnt=0, data_out=0, avg_out=0 and syn_out=0.
REQ-028 While res=1 at a clock edge, the block SHALL set syn_d=1, so a syn_in already high at reset release SHALL NOT produce a pulse.
REQ-029 res SHALL override clr and pulse; reset mid-frame SHALL discard the partial sum.

Verification
REQ-030 The bench SHALL cover: DW=8, LOG2N=4, SM_IN=1, data_in=8'h01, syn_in toggling every 5 clk -> after the 16th rising edge, syn_out one cycle, data_out=12'h010, avg_out=8'h01.
REQ-031 The bench SHALL cover: same setup, data_in=8'h81 (-1) -> data_out=12'hFFF0 truncated to 12'hFF0, avg_out=8'hFF; data_in=8'h80 (negative zero) -> data_out=0.
REQ-032 The bench SHALL cover these extremes with SM_IN=1: 8'h7F x16 -> data_out=12'h7F0, avg_out=8'h7F; 8'hFF x16 -> data_out=12'h810, avg_out=8'h81.
REQ-033 The bench SHALL cover SM_IN=0 with alternating 8'h03 and 8'hFC over 16 samples -> data_out=12'hFF8 (-8), avg_out=8'hFF (floor of -0.5).
REQ-034 The bench SHALL cover clr after 7 pulses (also once coincident with a pulse) -> cnt_out=0, data_out unchanged; the next syn_out comes only after 16 further pulses.
REQ-035 The bench SHALL cover res=1 for 3 cycles at cnt=9 with syn_in held high through release -> all outputs 0, no pulse at release, the first counted sample is the next rising edge.
